gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Parametrised dynamic branch predictor that replaces the static predictors behind branch_controller.
- Keeps the same request and feedback port set as those predictors, so it drops into the PREDICTOR slot unchanged.
- Holds a table of 2^INDEX_BITS saturating counters, indexed by PC alone (bimodal) or by PC XOR a global history register (gshare).
- Adds a post-reset table-initialisation sweep and saturating accuracy statistics.

Parameters:
- INDEX_BITS, 8: log2 of counter-table depth (legal 2..12).
- HIST_BITS, 8: global history length (legal 0..INDEX_BITS); 0 forces bimodal indexing.
- CTR_BITS, 2: counter width (legal 1..4).
- MODE, 1: 0 = bimodal (index = PC only), 1 = gshare (index = PC XOR history).
- STAT_BITS, 32: width of each statistics counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- i_req_valid  in  1  prediction request (conditional branch in decode)
- i_req_pc  in  `ADDR_WIDTH  branch PC
- i_req_target  in  `ADDR_WIDTH  decoded branch target (used only during INIT)
- o_req_prediction  out  BranchOutcome  TAKEN / NOT_TAKEN
- i_fb_valid  in  1  resolved-branch feedback strobe from EX
- i_fb_pc  in  `ADDR_WIDTH  resolved branch PC
- i_fb_prediction  in  BranchOutcome  prediction that was made for this branch
- i_fb_outcome  in  BranchOutcome  actual outcome
- o_ready  out  1  table initialised; dynamic prediction active
- o_stat_branches  out  STAT_BITS  count of accepted feedbacks
- o_stat_mispredicts  out  STAT_BITS  count of accepted feedbacks where i_fb_prediction != i_fb_outcome

Behaviour:
- Reset and clock: rst_n is synchronous, active-low; clock is clk. All state is rising-edge.
- Reset values: FSM = INIT, init pointer = 0, GHR = 0, o_ready = 0, both stats = 0. Table contents are undefined until the sweep completes.
- INIT state:
  - Each cycle writes WEAK_T = 2^(CTR_BITS-1) to entry[ptr], then ptr++.
  - After writing entry 2^INDEX_BITS-1, go to RUN next cycle; o_ready = 1 from that cycle.
  - The sweep lasts exactly 2^INDEX_BITS cycles after reset deassertion.
- Reset asserted mid-INIT or mid-RUN: return to INIT with pointer = 0 and restart the full sweep.
- Index function:
  - pcidx = pc[INDEX_BITS+1:2].
  - MODE=1 and HIST_BITS>0: idx = pcidx XOR zero-extended GHR[HIST_BITS-1:0].
  - Otherwise: idx = pcidx.
- Prediction, combinational, 0-cycle latency:
  - RUN: TAKEN iff MSB of entry[idx(i_req_pc)] = 1.
  - INIT: backward-taken/forward-not-taken, i.e. TAKEN iff i_req_pc > i_req_target (unsigned).
  - o_req_prediction is driven regardless of i_req_valid; i_req_valid has no state effect.
- Feedback (RUN only; i_fb_valid in INIT is ignored, with no stats or GHR change):
  - Compute fidx = idx(i_fb_pc) using the pre-update GHR.
  - TAKEN: entry[fidx] increments, saturating at 2^CTR_BITS-1.
  - NOT_TAKEN: entry[fidx] decrements, saturating at 0.
  - GHR <= {GHR[HIST_BITS-2:0], outcome==TAKEN}, updated non-speculatively in the same edge.
  - o_stat_branches increments; o_stat_mispredicts increments on mismatch. Both saturate at all-ones and never wrap.
- Simultaneous request and feedback hitting the same entry: the request sees the pre-update value (read-before-write). The updated value is visible from the next cycle.
- Table storage: flops or a distributed array with asynchronous read, one write port. The INIT write and the feedback write are mutually exclusive by state.

Test Plan:
- Reset with INDEX_BITS=4: o_ready = 0 for exactly 16 cycles, then 1. During INIT, pc=0x100 with target=0x0F0 -> TAKEN; pc=0x100 with target=0x110 -> NOT_TAKEN.
- MODE=0, CTR_BITS=2, post-init: pc=0x40 predicts TAKEN (counter=2). Two NOT_TAKEN feedbacks on 0x40 -> NOT_TAKEN. Three more -> counter stays 0. Two TAKEN feedbacks -> TAKEN again.
- MODE=1, HIST_BITS=2, INDEX_BITS=4: feedback outcomes T, T -> GHR = 2'b11. Next TAKEN feedback on pc=0x10 (pcidx 4) updates entry 7, not entry 4. Entry 4 is verified unchanged via a MODE=0 comparison model.
- Same-cycle request and NOT_TAKEN feedback on pc=0x40 with counter=2 -> same-cycle prediction TAKEN; following-cycle prediction NOT_TAKEN.
- Stats with STAT_BITS=3: 9 feedbacks, 4 mismatched -> o_stat_branches = 7 (saturated), o_stat_mispredicts = 4. Feedback during INIT leaves both at 0.
- Reset pulsed at init cycle 5 -> o_ready stays 0 for a fresh 2^INDEX_BITS cycles; all entries read back WEAK_T afterwards.

Source files
------------

// File: rtl/gshare_predictor.sv
// gshare_predictor: bimodal/gshare branch predictor with post-reset table sweep and accuracy stats
package gshare_pkg;
    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;
endpackage

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module gshare_predictor
    import gshare_pkg::*;
#(
    parameter int INDEX_BITS = 8,
    parameter int HIST_BITS  = 8,
    parameter int CTR_BITS   = 2,
    parameter int MODE       = 1,
    parameter int STAT_BITS  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req_valid,
    input  logic [`ADDR_WIDTH-1:0] i_req_pc,
    input  logic [`ADDR_WIDTH-1:0] i_req_target,
    output BranchOutcome           o_req_prediction,
    input  logic                   i_fb_valid,
    input  logic [`ADDR_WIDTH-1:0] i_fb_pc,
    input  BranchOutcome           i_fb_prediction,
    input  BranchOutcome           i_fb_outcome,
    output logic                   o_ready,
    output logic [STAT_BITS-1:0]   o_stat_branches,
    output logic [STAT_BITS-1:0]   o_stat_mispredicts
);
    localparam int DEPTH = 2 ** INDEX_BITS;
    localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam bit USE_HIST = (MODE == 1) && (HIST_BITS > 0);
    localparam logic [CTR_BITS-1:0] WEAK_T = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [GW-1:0]         ghr_q, ghr_d;
    logic [STAT_BITS-1:0]  br_q, br_d, mis_q, mis_d;
    logic [CTR_BITS-1:0]   table_q [DEPTH];
    logic                  we;
    logic [INDEX_BITS-1:0] waddr, hist, ridx, fidx;
    logic [CTR_BITS-1:0]   wdata, fctr;
    logic                  taken;
    logic                  unused_ok;

    assign hist = USE_HIST ? INDEX_BITS'(ghr_q) : '0;
    assign ridx = i_req_pc[INDEX_BITS+1:2] ^ hist;
    assign fidx = i_fb_pc[INDEX_BITS+1:2] ^ hist;
    assign fctr = table_q[fidx];
    assign taken = i_fb_outcome == TAKEN;
    assign o_ready = state_q == S_RUN;
    assign o_req_prediction = (state_q == S_RUN) ? (table_q[ridx][CTR_BITS-1] ? TAKEN : NOT_TAKEN)
                                                 : ((i_req_pc > i_req_target) ? TAKEN : NOT_TAKEN);
    assign o_stat_branches = br_q;
    assign o_stat_mispredicts = mis_q;
    assign unused_ok = ^{i_req_valid, i_fb_pc};

    // Next state: INIT sweeps WEAK_T through the table; RUN trains on feedback, shifts history, counts stats
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ghr_d   = ghr_q;
        br_d    = br_q;
        mis_d   = mis_q;
        we      = 1'b0;
        waddr   = fidx;
        wdata   = taken ? ((fctr == '1) ? fctr : fctr + 1'b1) : ((fctr == '0) ? fctr : fctr - 1'b1);
        if (state_q == S_INIT) begin
            we    = 1'b1;
            waddr = ptr_q;
            wdata = WEAK_T;
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = S_RUN;
        end else if (i_fb_valid) begin
            we    = 1'b1;
            ghr_d = GW'({ghr_q, taken});
            br_d  = (br_q == '1) ? br_q : br_q + 1'b1;
            if (i_fb_prediction != i_fb_outcome && mis_q != '1) mis_d = mis_q + 1'b1;
        end
    end

    // Control state, history and statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
            br_q    <= '0;
            mis_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
            br_q    <= br_d;
            mis_q   <= mis_d;
        end
    end

    // Counter table: single write port, asynchronous read, contents only defined after the sweep
    always_ff @(posedge clk) begin
        if (we) table_q[waddr] <= wdata;
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: gshare and bimodal instances checked against a behavioural model
module tb_gshare_predictor;
    import gshare_pkg::*;

    logic         clk, rst_n, req_valid, fb_valid;
    logic [31:0]  req_pc, req_tgt, fb_pc;
    BranchOutcome fb_pred, fb_out, pred_g, pred_b;
    logic         rdy_g, rdy_b;
    logic [2:0]   br_g, mis_g;
    logic [7:0]   br_b, mis_b;

    int checks = 0;
    int errors = 0;

    int  tab_g[16], tab_b[16];
    int  mcnt, mghr, sbg, smg, sbb, smb;
    bit  mvalid = 0;

    gshare_predictor #(.INDEX_BITS(4), .HIST_BITS(2), .CTR_BITS(2), .MODE(1), .STAT_BITS(3)) dut_g (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_pc(req_pc), .i_req_target(req_tgt),
        .o_req_prediction(pred_g), .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_prediction(fb_pred),
        .i_fb_outcome(fb_out), .o_ready(rdy_g), .o_stat_branches(br_g), .o_stat_mispredicts(mis_g)
    );

    gshare_predictor #(.INDEX_BITS(4), .HIST_BITS(2), .CTR_BITS(2), .MODE(0), .STAT_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_pc(req_pc), .i_req_target(req_tgt),
        .o_req_prediction(pred_b), .i_fb_valid(fb_valid), .i_fb_pc(fb_pc), .i_fb_prediction(fb_pred),
        .i_fb_outcome(fb_out), .o_ready(rdy_b), .o_stat_branches(br_b), .o_stat_mispredicts(mis_b)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic BranchOutcome mpred(input bit g, input logic [31:0] pc, input logic [31:0] tgt);
        int i;
        i = int'((pc >> 2) & 32'hF) ^ (g ? mghr : 0);
        if (mcnt < 16) return (pc > tgt) ? TAKEN : NOT_TAKEN;
        return ((g ? tab_g[i] : tab_b[i]) >= 2) ? TAKEN : NOT_TAKEN;
    endfunction

    // Compare against the model, then advance the model with the inputs the next edge will sample
    always @(negedge clk) begin
        int ig, ib, t;
        if (mvalid) begin
            chk("ready_g", rdy_g, mcnt == 16);
            chk("ready_b", rdy_b, mcnt == 16);
            chk("pred_g", pred_g, mpred(1, req_pc, req_tgt));
            chk("pred_b", pred_b, mpred(0, req_pc, req_tgt));
            chk("br_g", br_g, sbg);
            chk("mis_g", mis_g, smg);
            chk("br_b", br_b, sbb);
            chk("mis_b", mis_b, smb);
        end
        if (!rst_n) begin
            mvalid = 1;
            mcnt = 0; mghr = 0; sbg = 0; smg = 0; sbb = 0; smb = 0;
        end else if (mcnt < 16) begin
            mcnt++;
            if (mcnt == 16) for (int i = 0; i < 16; i++) begin tab_g[i] = 2; tab_b[i] = 2; end
        end else if (fb_valid) begin
            t  = (fb_out == TAKEN) ? 1 : 0;
            ib = int'((fb_pc >> 2) & 32'hF);
            ig = ib ^ mghr;
            tab_g[ig] = t ? ((tab_g[ig] < 3) ? tab_g[ig] + 1 : 3) : ((tab_g[ig] > 0) ? tab_g[ig] - 1 : 0);
            tab_b[ib] = t ? ((tab_b[ib] < 3) ? tab_b[ib] + 1 : 3) : ((tab_b[ib] > 0) ? tab_b[ib] - 1 : 0);
            mghr = ((mghr << 1) | t) & 3;
            sbg = (sbg < 7) ? sbg + 1 : 7;
            sbb = (sbb < 255) ? sbb + 1 : 255;
            if (fb_pred != fb_out) begin
                smg = (smg < 7) ? smg + 1 : 7;
                smb = (smb < 255) ? smb + 1 : 255;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fb(input logic [31:0] pc, input BranchOutcome o, input BranchOutcome p);
        fb_valid = 1; fb_pc = pc; fb_out = o; fb_pred = p;
        cyc();
        fb_valid = 0;
    endtask

    task automatic req_chk(input string nm, input logic [31:0] pc, input BranchOutcome eg, input BranchOutcome eb);
        cyc();
        req_pc = pc; req_tgt = 0;
        #1;
        chk({nm, "_g"}, pred_g, eg);
        chk({nm, "_b"}, pred_b, eb);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!rdy_g && n < 100) begin
            n++;
            cyc();
        end
        chk("init_len", n, 16);
    endtask

    task automatic do_reset(input int mid);
        rst_n = 0;
        cyc();
        rst_n = 1;
        if (mid > 0) begin
            repeat (mid) cyc();
            rst_n = 0;
            cyc();
            rst_n = 1;
        end
        wait_ready();
    endtask

    initial begin
        int n;
        rst_n = 0; req_valid = 0; req_pc = 0; req_tgt = 0;
        fb_valid = 0; fb_pc = 0; fb_pred = NOT_TAKEN; fb_out = NOT_TAKEN;
        cyc(); cyc();
        rst_n = 1;
        // INIT: BTFN prediction, feedback ignored, sweep length
        n = 0;
        while (!rdy_g && n < 100) begin
            req_pc = 32'h100;
            req_tgt = (n % 2) ? 32'h0F0 : 32'h110;
            fb_valid = 1; fb_pc = 32'h40; fb_pred = TAKEN; fb_out = NOT_TAKEN;
            #1;
            chk("btfn_g", pred_g, (n % 2) ? TAKEN : NOT_TAKEN);
            chk("btfn_b", pred_b, (n % 2) ? TAKEN : NOT_TAKEN);
            n++;
            cyc();
        end
        fb_valid = 0;
        chk("init_len", n, 16);
        chk("init_br_g", br_g, 0);
        chk("init_mis_b", mis_b, 0);
        // Counter training and saturation on pc 0x40
        req_chk("b_init", 32'h40, TAKEN, TAKEN);
        fb(32'h40, NOT_TAKEN, TAKEN);
        fb(32'h40, NOT_TAKEN, TAKEN);
        req_chk("b_nt2", 32'h40, NOT_TAKEN, NOT_TAKEN);
        repeat (3) fb(32'h40, NOT_TAKEN, NOT_TAKEN);
        req_chk("b_sat0", 32'h40, NOT_TAKEN, NOT_TAKEN);
        fb(32'h40, TAKEN, NOT_TAKEN);
        req_chk("b_t1", 32'h40, TAKEN, NOT_TAKEN);
        fb(32'h40, TAKEN, NOT_TAKEN);
        req_chk("b_t2", 32'h40, TAKEN, TAKEN);
        // Read-before-write on a same-cycle request and feedback
        cyc();
        req_pc = 32'h40;
        fb_valid = 1; fb_pc = 32'h40; fb_out = NOT_TAKEN; fb_pred = TAKEN;
        #1;
        chk("rbw_pre_b", pred_b, TAKEN);
        chk("rbw_pre_g", pred_g, TAKEN);
        cyc();
        fb_valid = 0;
        #1;
        chk("rbw_post_b", pred_b, NOT_TAKEN);
        chk("rbw_post_g", pred_g, TAKEN);
        // History indexing after a mid-run reset
        do_reset(0);
        fb(32'h1C, NOT_TAKEN, TAKEN);
        fb(32'h00, TAKEN, TAKEN);
        fb(32'h00, TAKEN, TAKEN);
        fb(32'h10, TAKEN, TAKEN);
        req_chk("ghr_e7", 32'h10, TAKEN, TAKEN);
        req_chk("ghr_e4", 32'h1C, TAKEN, NOT_TAKEN);
        // Reset pulsed mid-sweep restarts it; table reads back WEAK_T
        do_reset(5);
        for (int i = 0; i < 16; i++) req_chk("weak", i * 4, TAKEN, TAKEN);
        for (int i = 0; i < 9; i++) fb(i * 4, NOT_TAKEN, (i < 4) ? TAKEN : NOT_TAKEN);
        #1;
        chk("stat_br_g", br_g, 7);
        chk("stat_mis_g", mis_g, 4);
        chk("stat_br_b", br_b, 9);
        chk("stat_mis_b", mis_b, 4);
        for (int i = 0; i < 16; i++) req_chk("weak_dec", i * 4, (i < 9) ? NOT_TAKEN : TAKEN, (i < 9) ? NOT_TAKEN : TAKEN);
        // Random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            req_valid = $urandom_range(0, 1);
            req_pc = $urandom;
            req_tgt = $urandom_range(0, 1) ? $urandom : req_pc ^ 32'($urandom_range(0, 255));
            fb_valid = ($urandom_range(0, 2) != 0);
            fb_pc = $urandom;
            fb_out = $urandom_range(0, 1) ? TAKEN : NOT_TAKEN;
            fb_pred = $urandom_range(0, 1) ? TAKEN : NOT_TAKEN;
            cyc();
        end
        rst_n = 1; fb_valid = 0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
